// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control FSM with addi/bne, memory-ready wait, illegal-op pulse and retire counter; define MC_CTRL_JAL_EN to add jal.
module mc_ctrl_fsm #(
  parameter int STATE_W = 4,
  parameter int CNT_W = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               alusrca,
  output logic               regwrite,
  output logic               regdst,
  output logic [1:0]         pcsource,
  output logic [1:0]         aluop,
  output logic [1:0]         alusrcb,
  output logic               branch_ne,
  output logic               link,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   instret
);
  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXEC    = STATE_W'(6),
    RWB     = STATE_W'(7),
    BEQ     = STATE_W'(8),
    JUMP    = STATE_W'(9),
    ADDI_EX = STATE_W'(10),
    ADDI_WB = STATE_W'(11),
    BNE     = STATE_W'(12),
    JAL     = STATE_W'(13)
  } state_t;
  state_t st, nxt, dec_nxt;
  logic [CNT_W-1:0] cnt;
  logic rdy, op_lw, op_sw, op_r, op_beq, op_j, op_addi, op_bne, op_jal;
  logic in_fetch, in_decode, in_memadr, in_memrd, in_memwb, in_memwr, in_exec;
  logic in_rwb, in_beq, in_jump, in_addiex, in_addiwb, in_bne, in_jal, retire;
  assign rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign op_lw = op == 6'b100011;
  assign op_sw = op == 6'b101011;
  assign op_r = op == 6'b000000;
  assign op_beq = op == 6'b000100;
  assign op_j = op == 6'b000010;
  assign op_addi = op == 6'b001000;
  assign op_bne = op == 6'b000101;
`ifdef MC_CTRL_JAL_EN
  assign op_jal = op == 6'b000011;
`else
  assign op_jal = 1'b0;
`endif
  // Reset masks every decoded strobe so all outputs read 0 during the reset cycle
  assign in_fetch = !reset && st == FETCH;
  assign in_decode = !reset && st == DECODE;
  assign in_memadr = !reset && st == MEMADR;
  assign in_memrd = !reset && st == MEMRD;
  assign in_memwb = !reset && st == MEMWB;
  assign in_memwr = !reset && st == MEMWR;
  assign in_exec = !reset && st == EXEC;
  assign in_rwb = !reset && st == RWB;
  assign in_beq = !reset && st == BEQ;
  assign in_jump = !reset && st == JUMP;
  assign in_addiex = !reset && st == ADDI_EX;
  assign in_addiwb = !reset && st == ADDI_WB;
  assign in_bne = !reset && st == BNE;
  assign in_jal = !reset && st == JAL;
  always_comb begin
    dec_nxt = (op_lw || op_sw) ? MEMADR : op_r ? EXEC : op_beq ? BEQ : op_j ? JUMP :
              op_addi ? ADDI_EX : op_bne ? BNE : op_jal ? JAL : FETCH;
    case (st)
      FETCH:   nxt = rdy ? DECODE : FETCH;
      DECODE:  nxt = dec_nxt;
      MEMADR:  nxt = op_lw ? MEMRD : MEMWR;
      MEMRD:   nxt = rdy ? MEMWB : MEMRD;
      MEMWR:   nxt = rdy ? FETCH : MEMWR;
      EXEC:    nxt = RWB;
      ADDI_EX: nxt = ADDI_WB;
      default: nxt = FETCH;
    endcase
  end
  assign retire = in_memwb || in_rwb || in_beq || in_bne || in_jump || in_addiwb || in_jal ||
                  (in_memwr && rdy);
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= cnt + CNT_W'(retire);
    end
  end
  assign pcwrite = (in_fetch && rdy) || in_jump || in_jal;
  assign pcwritecond = in_beq || in_bne;
  assign iord = in_memrd || in_memwr;
  assign memread = in_fetch || in_memrd;
  assign memwrite = in_memwr;
  assign irwrite = in_fetch && rdy;
  assign memtoreg = in_memwb;
  assign alusrca = in_memadr || in_exec || in_beq || in_bne || in_addiex;
  assign regwrite = in_memwb || in_rwb || in_addiwb || in_jal;
  assign regdst = in_rwb;
  assign pcsource = (in_jump || in_jal) ? 2'b10 : (in_beq || in_bne) ? 2'b01 : 2'b00;
  assign aluop = in_exec ? 2'b10 : (in_beq || in_bne) ? 2'b01 : 2'b00;
  assign alusrcb = in_fetch ? 2'b01 : in_decode ? 2'b11 : (in_memadr || in_addiex) ? 2'b10 : 2'b00;
  assign branch_ne = in_bne;
`ifdef MC_CTRL_JAL_EN
  assign link = in_jal;
`else
  assign link = 1'b0;
`endif
  assign illegal_op = in_decode && dec_nxt == FETCH;
  assign state = reset ? '0 : st;
  assign instret = reset ? '0 : cnt;
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Sequential multicycle MIPS control unit. It holds its own state register and decodes every datapath control strobe from that state. It extends the existing 10-state lw/sw/R-type/beq/j controller with the following:
- addi and bne instructions.
- A memory-ready wait handshake.
- Illegal-opcode detection.
- A retired-instruction counter.

It sits between the instruction register opcode field and the multicycle datapath.

Parameters:
STATE_W, 4, state register width; must be >= 4.
CNT_W, 32, retired-instruction counter width.
MEM_WAIT, 1, 1 = honour mem_ready; 0 = mem_ready internally forced to 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
op  in  6  opcode, IR[31:26].
mem_ready  in  1  memory has completed the current read/write this cycle.
pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, alusrca, regwrite, regdst  out  1 each  datapath strobes.
pcsource  out  2  PC mux select.
aluop  out  2  ALU control select.
alusrcb  out  2  ALU B mux select.
branch_ne  out  1  inverts the zero flag for pcwritecond.
link  out  1  JAL writeback: destination reg 31, data = PC.
illegal_op  out  1  one-cycle pulse.
state  out  STATE_W  current state, for debug.
instret  out  CNT_W  retired-instruction count.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7.
  - BEQ=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, BNE=12, JAL=13.
  - 14 and 15 are unused; from an unused state the next state is FETCH.
- Reset: while reset=1, the state register loads FETCH and instret loads 0. All outputs are forced to 0 during reset, including state and instret as seen that cycle. Reset taken mid-instruction abandons it with no retire. Control decode resumes on the first cycle after reset is released.
- Control outputs are a Moore decode of the state register. The only exception is the mem_ready gating noted below. Any signal not listed for a state is 0.
- FETCH:
  - memread=1, alusrcb=01.
  - irwrite=pcwrite=mem_ready, pcsource=00, aluop=00.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - alusrcb=11.
  - Next state by op: 100011 and 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BEQ; 000010 -> JUMP; 001000 -> ADDI_EX; 000101 -> BNE; 000011 -> JAL (JAL only when MC_CTRL_JAL_EN is defined).
  - Any other op goes to FETCH with illegal_op=1 for exactly that DECODE cycle. No retire.
- MEMADR: alusrca=1, alusrcb=10. Goes to MEMRD if op=100011, else to MEMWR.
- MEMRD: memread=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: regwrite=1, memtoreg=1. Goes to FETCH.
- MEMWR: memwrite=1, iord=1. Memwrite stays asserted every wait cycle. Goes to FETCH when mem_ready=1.
- EXEC: alusrca=1, aluop=10. Goes to RWB.
- RWB: regwrite=1, regdst=1. Goes to FETCH.
- BEQ: alusrca=1, aluop=01, pcwritecond=1, pcsource=01. Goes to FETCH.
- BNE: same as BEQ plus branch_ne=1.
- JUMP: pcwrite=1, pcsource=10. Goes to FETCH.
- ADDI_EX: alusrca=1, alusrcb=10. Goes to ADDI_WB.
- ADDI_WB: regwrite=1. Goes to FETCH.
- Retire:
  - instret increments by 1 on the clock edge that transitions from MEMWB, MEMWR (with mem_ready=1), RWB, BEQ, BNE, JUMP, ADDI_WB or JAL into FETCH.
  - The counter wraps from all-ones to 0 with no flag.
- op is sampled only in DECODE and MEMADR. Changes to op in other states have no effect.
- With MEM_WAIT=0, FETCH, MEMRD and MEMWR each last exactly one cycle. Resulting CPI: lw=5, sw=4, R-type=4, addi=4, branch=3, j=3.

Optional Feature:
MC_CTRL_JAL_EN:
- Defined: op 000011 goes DECODE -> JAL. JAL asserts pcwrite=1, pcsource=10, regwrite=1, link=1, then goes to FETCH and retires.
- Undefined: op 000011 is illegal (illegal_op pulse, return to FETCH), and link is tied to 0.

Test Plan:
- Reset then lw (100011), mem_ready=1 throughout -> states 0,1,2,3,4,0; memread=1 in states 0 and 3; regwrite=memtoreg=1 in state 4; instret=1.
- sw (101011), mem_ready low 3 cycles in MEMWR -> state 5 held for 4 cycles with memwrite=1 each cycle; instret increments only on exit.
- bne (000101) -> states 0,1,12,0; in state 12: pcwritecond=1, branch_ne=1, pcsource=01, aluop=01.
- op=111111 in DECODE -> illegal_op=1 for one cycle; next state 0; instret unchanged.
- reset asserted during MEMRD -> next state 0, instret=0, all outputs 0 during the reset cycle.
- CNT_W=4, 16 R-type instructions (op 000000) -> instret wraps 15 -> 0; each instruction takes 4 cycles.
